// File: rtl/restoring_divider_pkg.sv
// -----------------------------------------------------------------------------
// div_defs : shared definitions for the restoring divider.
//   WIDTH_DEF - default operand width (divisor / quotient / remainder)
//   CNT_W     - width of the iteration counter
//   state_e   - controller FSM state encodings
// Imported by restoring_divider (top/datapath) and div_ctrl (controller).
// -----------------------------------------------------------------------------
package div_defs;

    localparam int WIDTH_DEF = 5;
    localparam int CNT_W     = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LD_HI = 3'd1,
        S_LD_LO = 3'd2,
        S_CALC  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/restoring_divider_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl : sequencing FSM for the restoring divider.
// Walks IDLE -> LD_HI -> LD_LO -> CALC (WIDTH steps) -> DONE and issues the
// load/shift strobes consumed by the datapath in restoring_divider.
// Optional feature macro: DIV_OVERFLOW_DET_EN (early exit on quotient overflow).
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   start       - request a new division (honoured in IDLE / DONE only)
//   ovf         - datapath compare A >= D (only with DIV_OVERFLOW_DET_EN)
//   busy, ready - status: busy in LD_HI/LD_LO/CALC, ready in DONE
//   ld_d/ld_a/ld_q - load strobes for divisor, high half, low half
//   shift       - one restoring step this cycle
//   ovf_done    - overflow shortcut taken (only with DIV_OVERFLOW_DET_EN)
// -----------------------------------------------------------------------------
module div_ctrl
    import div_defs::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
`ifdef DIV_OVERFLOW_DET_EN
    input  logic ovf,
    output logic ovf_done,
`endif
    output logic busy,
    output logic ready,
    output logic ld_d,
    output logic ld_a,
    output logic ld_q,
    output logic shift
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ld_d     = 1'b0;
        ld_a     = 1'b0;
        ld_q     = 1'b0;
        shift    = 1'b0;
`ifdef DIV_OVERFLOW_DET_EN
        ovf_done = 1'b0;
`endif
        busy     = (state_q == S_LD_HI) || (state_q == S_LD_LO) || (state_q == S_CALC);
        ready    = (state_q == S_DONE);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    ld_d    = 1'b1;
                    state_d = S_LD_HI;
                end
            end
            S_LD_HI: begin
                ld_a    = 1'b1;
                state_d = S_LD_LO;
            end
            S_LD_LO: begin
                ld_q    = 1'b1;
                cnt_d   = '0;
`ifdef DIV_OVERFLOW_DET_EN
                // A already holds the dividend high half; if it is >= D the
                // quotient cannot fit in WIDTH bits (this also catches D = 0).
                if (ovf) begin
                    ovf_done = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_CALC;
                end
`else
                state_d = S_CALC;
`endif
            end
            S_CALC: begin
                shift = 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: rtl/restoring_divider.sv
// -----------------------------------------------------------------------------
// restoring_divider : 2*WIDTH / WIDTH unsigned restoring divider with a
// serial operand bus. Operands arrive on data_in as divisor, dividend high
// half, dividend low half on consecutive cycles; WIDTH restoring steps follow.
// Optional feature macro: DIV_OVERFLOW_DET_EN (err on quotient overflow or
// divide-by-zero, result forced to Q = all ones, A = 0).
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - synchronous active-low reset
//   start     - begin a division (accepted in IDLE or DONE)
//   data_in   - serial operand bus [WIDTH]
//   sel       - output select: 0 = quotient, 1 = remainder
//   data_out  - selected result [WIDTH]
//   busy      - operation in progress
//   ready     - result valid
//   err       - overflow / divide-by-zero, valid while ready
// -----------------------------------------------------------------------------
module restoring_divider
    import div_defs::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             sel,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             ready,
    output logic             err
);

    logic [WIDTH-1:0]        d_q, d_d;
    logic [WIDTH-1:0]        a_q, a_d;
    logic [WIDTH-1:0]        q_q, q_d;
    logic signed [WIDTH:0]   trial;
    logic                    ld_d, ld_a, ld_q, shift;

`ifdef DIV_OVERFLOW_DET_EN
    logic                    ovf;
    logic                    ovf_done;
    logic                    err_q, err_d;

    assign ovf = (a_q >= d_q);
`endif

    div_ctrl #(
        .WIDTH    (WIDTH)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef DIV_OVERFLOW_DET_EN
        .ovf      (ovf),
        .ovf_done (ovf_done),
`endif
        .busy     (busy),
        .ready    (ready),
        .ld_d     (ld_d),
        .ld_a     (ld_a),
        .ld_q     (ld_q),
        .shift    (shift)
    );

    // Trial subtraction on the left-shifted partial remainder. Since A < D
    // holds on entry to every step, WIDTH+1 bits hold the result exactly and
    // the MSB is the borrow (negative) flag.
    assign trial = $signed({a_q, q_q[WIDTH-1]}) - $signed({1'b0, d_q});

    always_comb begin
        d_d = d_q;
        a_d = a_q;
        q_d = q_q;
        if (ld_d) d_d = data_in;
        if (ld_a) a_d = data_in;
        if (ld_q) q_d = data_in;
        if (shift) begin
            if (!trial[WIDTH]) begin
                a_d = trial[WIDTH-1:0];
                q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                a_d = {a_q[WIDTH-2:0], q_q[WIDTH-1]};
                q_d = {q_q[WIDTH-2:0], 1'b0};
            end
        end
`ifdef DIV_OVERFLOW_DET_EN
        // Saturated result overrides the low-half load in the same cycle.
        if (ovf_done) begin
            a_d = '0;
            q_d = '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q <= '0;
            a_q <= '0;
            q_q <= '0;
        end else begin
            d_q <= d_d;
            a_q <= a_d;
            q_q <= q_d;
        end
    end

`ifdef DIV_OVERFLOW_DET_EN
    always_comb begin
        err_d = err_q;
        if (ld_d)     err_d = 1'b0;
        if (ovf_done) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign data_out = sel ? a_q : q_q;

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;

    localparam int W = 5;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] data_in;
    logic         sel;
    logic [W-1:0] data_out;
    logic         busy;
    logic         ready;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    restoring_divider #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .sel      (sel),
        .data_out (data_out),
        .busy     (busy),
        .ready    (ready),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; leaves the caller 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds one operation starting at the next edge. lat counts edges with the
    // start edge as 1, up to and including the edge at which ready rises.
    task automatic run_div(input logic [W-1:0] d, input logic [W-1:0] hi,
                           input logic [W-1:0] lo, output int lat,
                           output logic busy1);
        start   = 1'b1;
        data_in = d;
        tick();
        busy1   = busy;
        start   = 1'b0;
        data_in = hi;
        tick();
        data_in = lo;
        tick();
        data_in = '0;
        lat = 3;
        while (ready !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic read_result(output logic [W-1:0] q, output logic [W-1:0] r);
        sel = 1'b0;
        #1;
        q = data_out;
        sel = 1'b1;
        #1;
        r = data_out;
        sel = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] q, r;
        rst_n   = 1'b0;
        start   = 1'b1;
        data_in = 5'd9;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 0", ready);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b expected 0", err);
        end
        read_result(q, r);
        n_checks++;
        if (q !== 5'd0 || r !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_data_out: got q=%0d r=%0d expected 0 0", q, r);
        end
        start   = 1'b0;
        data_in = '0;
        rst_n   = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        logic b1;
        logic [W-1:0] q, r;
        run_div(5'd7, 5'd3, 5'd4, lat, b1);
        n_checks++;
        if (b1 !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b expected 1", b1);
        end
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 8", lat);
        end
        read_result(q, r);
        n_checks++;
        if (q !== 5'd14 || r !== 5'd2) begin
            n_fail++;
            $display("FAIL basic_100_7: got q=%0d r=%0d expected 14 2", q, r);
        end
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_flags: got err=%b busy=%b expected 0 0", err, busy);
        end
    endtask

    task automatic test_max_quotient();
        int lat;
        logic b1;
        logic [W-1:0] q, r;
        run_div(5'd31, 5'd30, 5'd31, lat, b1);
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL max_latency: got %0d expected 8", lat);
        end
        read_result(q, r);
        n_checks++;
        if (q !== 5'd31 || r !== 5'd30) begin
            n_fail++;
            $display("FAIL max_991_31: got q=%0d r=%0d expected 31 30", q, r);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL max_err: got %b expected 0", err);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic b1;
        logic [W-1:0] q, r;
        run_div(5'd31, 5'd15, 5'd20, lat, b1);
        read_result(q, r);
        n_checks++;
        if (lat !== 8 || q !== 5'd16 || r !== 5'd4) begin
            n_fail++;
            $display("FAIL b2b_first_500_31: got lat=%0d q=%0d r=%0d expected 8 16 4", lat, q, r);
        end
        // Still in DONE: the next start is accepted on the very next edge.
        run_div(5'd7, 5'd3, 5'd4, lat, b1);
        n_checks++;
        if (b1 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b expected 1", b1);
        end
        read_result(q, r);
        n_checks++;
        if (lat !== 8 || q !== 5'd14 || r !== 5'd2) begin
            n_fail++;
            $display("FAIL b2b_second_100_7: got lat=%0d q=%0d r=%0d expected 8 14 2", lat, q, r);
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic b1;
        logic [W-1:0] q, r;
`ifdef DIV_OVERFLOW_DET_EN
        run_div(5'd0, 5'd1, 5'd0, lat, b1);
        read_result(q, r);
        n_checks++;
        if (lat !== 3 || err !== 1'b1 || q !== 5'd31 || r !== 5'd0) begin
            n_fail++;
            $display("FAIL ovf_div0: got lat=%0d err=%b q=%0d r=%0d expected 3 1 31 0", lat, err, q, r);
        end
        run_div(5'd31, 5'd31, 5'd8, lat, b1);
        read_result(q, r);
        n_checks++;
        if (lat !== 3 || err !== 1'b1 || q !== 5'd31 || r !== 5'd0) begin
            n_fail++;
            $display("FAIL ovf_1000_31: got lat=%0d err=%b q=%0d r=%0d expected 3 1 31 0", lat, err, q, r);
        end
        run_div(5'd7, 5'd3, 5'd4, lat, b1);
        read_result(q, r);
        n_checks++;
        if (err !== 1'b0 || q !== 5'd14 || r !== 5'd2) begin
            n_fail++;
            $display("FAIL ovf_err_clear: got err=%b q=%0d r=%0d expected 0 14 2", err, q, r);
        end
`else
        run_div(5'd0, 5'd1, 5'd0, lat, b1);
        read_result(q, r);
        n_checks++;
        if (lat !== 8 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL noovf_div0: got lat=%0d err=%b expected 8 0", lat, err);
        end
        run_div(5'd31, 5'd31, 5'd8, lat, b1);
        read_result(q, r);
        n_checks++;
        if (lat !== 8 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL noovf_1000_31: got lat=%0d err=%b expected 8 0", lat, err);
        end
`endif
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        logic b1;
        logic [W-1:0] q, r;
        start   = 1'b1;
        data_in = 5'd7;
        tick();
        start   = 1'b0;
        data_in = 5'd3;
        tick();
        data_in = 5'd4;
        tick();
        data_in = '0;
        tick();
        tick();
        // Next edge would be the third CALC step.
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL midcalc_flags: got busy=%b ready=%b err=%b expected 0 0 0", busy, ready, err);
        end
        read_result(q, r);
        n_checks++;
        if (q !== 5'd0 || r !== 5'd0) begin
            n_fail++;
            $display("FAIL midcalc_data_out: got q=%0d r=%0d expected 0 0", q, r);
        end
        rst_n = 1'b1;
        tick();
        run_div(5'd7, 5'd3, 5'd4, lat, b1);
        read_result(q, r);
        n_checks++;
        if (lat !== 8 || q !== 5'd14 || r !== 5'd2) begin
            n_fail++;
            $display("FAIL midcalc_recover: got lat=%0d q=%0d r=%0d expected 8 14 2", lat, q, r);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        logic [W-1:0] q, r;
        start   = 1'b1;
        data_in = 5'd7;
        tick();
        // LD_HI: start held high must not restart the operation.
        start   = 1'b1;
        data_in = 5'd3;
        tick();
        start   = 1'b0;
        data_in = 5'd4;
        tick();
        lat = 3;
        // Pulse start (with junk data) on the second CALC edge.
        data_in = 5'd31;
        tick();
        lat++;
        start = 1'b1;
        tick();
        lat++;
        start   = 1'b0;
        data_in = '0;
        while (ready !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d expected 8", lat);
        end
        read_result(q, r);
        n_checks++;
        if (q !== 5'd14 || r !== 5'd2) begin
            n_fail++;
            $display("FAIL ignore_result: got q=%0d r=%0d expected 14 2", q, r);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        sel     = 1'b0;
        test_reset();
        test_basic();
        test_max_quotient();
        test_back_to_back();
        test_overflow();
        test_reset_mid_calc();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
